// File: rtl/mem_arbiter.sv
// Two-port (cpu / dma) round-robin arbiter in front of a single synchronous RAM.
// Each grant runs IDLE -> ACCESS -> ACK, with a one-cycle ack pulse to the winner.
module mem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner,
    output logic          busy,
    output logic [7:0]    cpu_cnt,
    output logic [7:0]    dma_cnt
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] ACK    = 2'd2;

    logic [1:0]    state;
    logic          lat_we;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dma_rdata_q;
    logic          grant_dma;
    logic          any_req;
    logic          in_ack;

    // On a tie the port that was not granted last wins; owner resets to 1 so cpu wins first.
    always_comb begin
        any_req   = cpu_req | dma_req;
        grant_dma = dma_req & (~cpu_req | ~owner);
        in_ack    = (state == ACK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 1'b1;
            lat_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_cnt     <= '0;
            dma_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner     <= grant_dma;
                        lat_we    <= grant_dma ? dma_we    : cpu_we;
                        mem_addr  <= grant_dma ? dma_addr  : cpu_addr;
                        mem_wdata <= grant_dma ? dma_wdata : cpu_wdata;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= ACK;
                end
                ACK: begin
                    if (owner) begin
                        dma_cnt <= dma_cnt + 8'd1;
                        if (!lat_we)
                            dma_rdata_q <= mem_rdata;
                    end else begin
                        cpu_cnt <= cpu_cnt + 8'd1;
                        if (!lat_we)
                            cpu_rdata_q <= mem_rdata;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data is forwarded straight from the RAM during the ack cycle, then held in the register.
    always_comb begin
        mem_en    = (state == ACCESS);
        mem_we    = (state == ACCESS) & lat_we;
        busy      = (state != IDLE);
        cpu_ack   = in_ack & ~owner;
        dma_ack   = in_ack & owner;
        cpu_rdata = (cpu_ack && !lat_we) ? mem_rdata : cpu_rdata_q;
        dma_rdata = (dma_ack && !lat_we) ? mem_rdata : dma_rdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: inputs change on the falling edge,
// outputs are checked on the falling edge just before the inputs change.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [15:0] cpu_rdata, dma_rdata;
    logic        cpu_ack, dma_ack;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        owner, busy;
    logic [7:0]  cpu_cnt, dma_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(16), .DW(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner), .busy(busy),
        .cpu_cnt(cpu_cnt), .dma_cnt(dma_cnt)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        mem_rdata = '0;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_owner", owner, 1);
        check("rst_busy", busy, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_acks", {cpu_ack, dma_ack}, 0);
        check("rst_cnts", {cpu_cnt, dma_cnt}, 0);
        check("rst_rdata", {cpu_rdata, dma_rdata}, 0);
        reset = 1'b0;

        // CPU read alone
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        @(negedge clk);
        check("cr_mem_en", mem_en, 1);
        check("cr_mem_we", mem_we, 0);
        check("cr_mem_addr", mem_addr, 16'h0010);
        check("cr_owner", owner, 0);
        check("cr_busy", busy, 1);
        check("cr_early_ack", cpu_ack, 0);
        mem_rdata = 16'hBEEF;
        @(negedge clk);
        check("cr_ack", cpu_ack, 1);
        check("cr_dma_ack", dma_ack, 0);
        check("cr_mem_en_off", mem_en, 0);
        check("cr_rdata", cpu_rdata, 16'hBEEF);
        cpu_req = 1'b0;
        @(negedge clk);
        mem_rdata = 16'h0000;
        #1;
        check("cr_ack_gone", cpu_ack, 0);
        check("cr_cnt", cpu_cnt, 1);
        check("cr_rdata_hold", cpu_rdata, 16'hBEEF);
        check("cr_idle", busy, 0);

        // DMA write alone, address change during ACCESS must not leak through
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200; dma_wdata = 16'h1234;
        @(negedge clk);
        check("dw_mem_en", mem_en, 1);
        check("dw_mem_we", mem_we, 1);
        check("dw_mem_addr", mem_addr, 16'h0200);
        check("dw_mem_wdata", mem_wdata, 16'h1234);
        check("dw_owner", owner, 1);
        dma_addr = 16'hFFFF; dma_wdata = 16'h0000;
        @(negedge clk);
        check("dw_ack", dma_ack, 1);
        check("dw_cpu_ack", cpu_ack, 0);
        check("dw_addr_held", mem_addr, 16'h0200);
        check("dw_wdata_held", mem_wdata, 16'h1234);
        check("dw_mem_we_off", mem_we, 0);
        check("dw_rdata_keep", dma_rdata, 16'h0000);
        dma_req = 1'b0;
        @(negedge clk);
        check("dw_cnt", dma_cnt, 1);
        check("dw_cpu_cnt", cpu_cnt, 1);
        check("dw_cpu_rdata", cpu_rdata, 16'hBEEF);

        // Reset during ACCESS aborts the transaction
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0333; cpu_wdata = 16'h4444;
        @(negedge clk);
        check("ab_mem_en", mem_en, 1);
        #1 reset = 1'b1;
        #1;
        check("ab_mem_en_drop", mem_en, 0);
        check("ab_busy_drop", busy, 0);
        check("ab_mem_addr", mem_addr, 0);
        cpu_req = 1'b0;
        @(negedge clk);
        check("ab_no_ack", cpu_ack, 0);
        reset = 1'b0;
        @(negedge clk);
        check("ab_cnts", {cpu_cnt, dma_cnt}, 0);
        check("ab_idle", busy, 0);
        check("ab_owner", owner, 1);
        check("ab_acks", {cpu_ack, dma_ack}, 0);

        // Both requesting and held: cpu, dma, cpu, dma, 3 cycles per grant
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0AAA;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0BBB; dma_wdata = 16'h7777;
        mem_rdata = 16'h5555;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i % 3 == 0) begin
                check("rr_mem_en", mem_en, 1);
                check("rr_owner", owner, (i / 3) % 2);
                check("rr_mem_addr", mem_addr, ((i / 3) % 2 == 1) ? 16'h0BBB : 16'h0AAA);
            end else begin
                check("rr_mem_en_off", mem_en, 0);
            end
            check("rr_cpu_ack", cpu_ack, (i % 3 == 1) && ((i / 3) % 2 == 0));
            check("rr_dma_ack", dma_ack, (i % 3 == 1) && ((i / 3) % 2 == 1));
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        @(negedge clk);
        check("rr_cpu_cnt", cpu_cnt, 2);
        check("rr_dma_cnt", dma_cnt, 2);
        check("rr_cpu_rdata", cpu_rdata, 16'h5555);
        check("rr_dma_rdata", dma_rdata, 16'h0000);
        check("rr_idle", busy, 0);

        // CPU counter wrap: 2 + 253 = 255, one more wraps to 0
        cpu_we = 1'b0;
        for (int n = 0; n < 254; n++) begin
            cpu_req = 1'b1;
            @(negedge clk);
            @(negedge clk);
            cpu_req = 1'b0;
            @(negedge clk);
            if (n == 252) check("wrap_cnt_255", cpu_cnt, 255);
        end
        check("wrap_cnt_0", cpu_cnt, 0);
        check("wrap_dma_cnt", dma_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 16, address width; DW, 16, data width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 cpu_req  input  1  processor access request, held high until cpu_ack.
REQ-005 cpu_we  input  1  processor write (1) / read (0), stable while cpu_req high.
REQ-006 cpu_addr  input  AW  processor address; cpu_wdata  input  DW  processor write data.
REQ-007 cpu_rdata  output  DW  read data to processor; cpu_ack  output  1  one-cycle completion pulse.
REQ-008 dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack SHALL mirror REQ-004..007 for the loader/DMA port.
REQ-009 mem_en  output  1  memory cycle enable; mem_we  output  1  memory write strobe.
REQ-010 mem_addr  output  AW; mem_wdata  output  DW; mem_rdata  input  DW (synchronous RAM, valid one cycle after mem_en).
REQ-011 owner  output  1  port currently or last granted (0 = cpu, 1 = dma); busy  output  1  high in ACCESS or ACK.
REQ-012 cpu_cnt, dma_cnt  output  8 each  completed-access counters.

Function
REQ-013 FSM states SHALL be IDLE, ACCESS, ACK; no other states reachable.
REQ-014 IDLE: no request -> stay IDLE; any request -> latch winner, address, data and we; go ACCESS.
REQ-015 Arbitration SHALL be round-robin: both requesting -> grant the port not equal to owner; single requester -> grant it.
REQ-016 ACCESS: mem_en = 1, mem_we = latched we, mem_addr/mem_wdata = latched values; always go ACK next cycle.
REQ-017 ACK: capture mem_rdata into winner's rdata register (reads only), pulse winner's ack for exactly one cycle, increment winner's counter, go IDLE.
REQ-018 Latency: request sampled at edge k -> mem_en high in cycle k+1 -> ack high in cycle k+2; minimum 3 cycles between successive grants.
REQ-019 Requester SHALL drop req in the cycle after ack; req still high in IDLE is a new request.
REQ-020 Outside ACCESS, mem_en and mem_we SHALL be 0; mem_addr/mem_wdata hold last latched values.
REQ-021 Loser's ack SHALL stay 0; loser's request remains pending and wins next arbitration.
REQ-022 Changes on req, we, addr or wdata after latch (ACCESS/ACK) SHALL not affect the current transaction.
REQ-023 Read data registers SHALL hold value until that port's next completed read; writes leave them unchanged.
REQ-024 Counters SHALL wrap 255 -> 0 without flag.
REQ-025 Request dropped before grant SHALL be ignored without side effect.

Reset
REQ-026 On reset: state IDLE, owner = 1 (cpu wins first tie), all acks 0, mem_en/mem_we 0, mem_addr/mem_wdata 0, rdata registers 0, counters 0, busy 0.
REQ-027 Reset mid-transaction SHALL abort it: no ack, no counter increment, mem_en drops immediately.
REQ-028 First rising edge after reset release SHALL be a normal IDLE evaluation.

Verification
REQ-029 CPU read alone: cpu_req=1, cpu_we=0, cpu_addr=0x0010, mem_rdata=0xBEEF in cycle k+2 -> mem_en at k+1 with mem_addr=0x0010, cpu_ack at k+2, cpu_rdata=0xBEEF, cpu_cnt=1.
REQ-030 DMA write alone: dma_we=1, dma_addr=0x0200, dma_wdata=0x1234 -> mem_we=1 with those values at k+1, dma_ack at k+2, dma_rdata unchanged, dma_cnt=1.
REQ-031 Simultaneous requests after reset, both held -> grants alternate cpu, dma, cpu, dma; acks 3 cycles apart; no double ack.
REQ-032 Reset asserted during ACCESS -> mem_en 0 at once, no ack, counters 0, state IDLE after release.
REQ-033 256 CPU accesses -> cpu_cnt wraps to 0; dma_cnt unaffected.
REQ-034 Address changed to 0xFFFF during ACCESS -> mem_addr keeps latched value.
